// File: rtl/dmem_vec_ram.sv
// rtl/dmem_vec_ram.sv - single-port word memory with scalar/vector access and full-array dump
// One lane per clock in ACCESS; DUMP streams every word out with registered outputs.
module dmem_vec_ram #(
  parameter int S = 32,
  parameter int LANES = 6,
  parameter int DEPTH = 30015,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  output logic                 ready,
  input  logic                 we,
  input  logic                 is_vector,
  input  logic [AW-1:0]        address,
  input  logic [S*LANES-1:0]   wd,
  output logic [S*LANES-1:0]   rd,
  output logic                 done,
  output logic                 err,
  input  logic                 dump_start,
  output logic                 dump_valid,
  output logic [AW-1:0]        dump_addr,
  output logic [S-1:0]         dump_data,
  output logic                 dump_done
);

  localparam int KW = $clog2(LANES + 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [KW-1:0] LAST_LANE = KW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DUMP} state_t;

  state_t               state_q;
  logic                 we_q;
  logic                 vec_q;
  logic                 err_acc_q;
  logic [AW-1:0]        addr_q;
  logic [S*LANES-1:0]   wd_q;
  logic [S*LANES-1:0]   rd_q;
  logic [KW-1:0]        k_q;
  logic                 done_q;
  logic                 err_q;
  logic [AW-1:0]        dump_cnt_q;
  logic                 dump_valid_q;
  logic [AW-1:0]        dump_addr_q;
  logic [S-1:0]         dump_data_q;
  logic                 dump_done_q;

  logic [S-1:0] mem [DEPTH] = '{default: '0};

  logic [AW:0]   lane_addr;
  logic [AW-1:0] lane_idx;
  logic          lane_ok;
  logic          lane_last;
  logic [S-1:0]  lane_wd;
  logic [S-1:0]  lane_rd;

  // Extra address bit keeps address+k from wrapping back into the array.
  assign lane_addr = {1'b0, addr_q} + (AW+1)'(k_q);
  assign lane_idx  = lane_addr[AW-1:0];
  assign lane_ok   = (lane_addr < DEPTH_W);
  assign lane_last = vec_q ? (k_q == LAST_LANE) : 1'b1;
  assign lane_wd   = wd_q[k_q*S +: S];
  assign lane_rd   = lane_ok ? mem[lane_idx] : '0;

  assign ready      = (state_q == IDLE) & ~dump_start;
  assign rd         = rd_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_done  = dump_done_q;

  always_ff @(posedge clk) begin
    if (state_q == ACCESS && we_q && lane_ok) begin
      mem[lane_idx] <= lane_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      vec_q        <= 1'b0;
      err_acc_q    <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      rd_q         <= '0;
      k_q          <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dump_cnt_q   <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dump_start) begin
            dump_cnt_q <= '0;
            state_q    <= DUMP;
          end else if (req) begin
            we_q      <= we;
            vec_q     <= is_vector;
            addr_q    <= address;
            wd_q      <= wd;
            k_q       <= '0;
            err_acc_q <= 1'b0;
            if (!we) begin
              rd_q <= '0;
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rd_q[k_q*S +: S] <= lane_rd;
          end
          if (lane_last) begin
            done_q  <= 1'b1;
            err_q   <= err_acc_q | ~lane_ok;
            state_q <= IDLE;
          end else begin
            k_q       <= k_q + KW'(1);
            err_acc_q <= err_acc_q | ~lane_ok;
          end
        end
        DUMP: begin
          dump_valid_q <= 1'b1;
          dump_addr_q  <= dump_cnt_q;
          dump_data_q  <= mem[dump_cnt_q];
          dump_done_q  <= (dump_cnt_q == LAST_ADDR);
          if (dump_cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
          end else begin
            dump_cnt_q <= dump_cnt_q + AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_vec_ram.sv
// tb/tb_dmem_vec_ram.sv - directed vector bench for dmem_vec_ram (DEPTH=16, LANES=4, S=32)
module tb_dmem_vec_ram;

  localparam int S = 32;
  localparam int L = 4;
  localparam int D = 16;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic             ready;
  logic             we = 1'b0;
  logic             is_vector = 1'b0;
  logic [AW-1:0]    address = '0;
  logic [S*L-1:0]   wd = '0;
  logic [S*L-1:0]   rd;
  logic             done;
  logic             err;
  logic             dump_start = 1'b0;
  logic             dump_valid;
  logic [AW-1:0]    dump_addr;
  logic [S-1:0]     dump_data;
  logic             dump_done;

  dmem_vec_ram #(.S(S), .LANES(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .we(we), .is_vector(is_vector),
    .address(address), .wd(wd), .rd(rd), .done(done), .err(err),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           w;
    logic           v;
    logic [AW-1:0]  a;
    logic [S*L-1:0] d;
    logic [S*L-1:0] exp_rd;
    logic           exp_err;
    int             exp_lat;
  } vec_t;

  vec_t tv [14];
  logic [S-1:0] tb_mem [D];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [S*L-1:0] act, input logic [S*L-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic v, input logic [AW-1:0] a,
                        input logic [S*L-1:0] d, output logic [S*L-1:0] r,
                        output logic e, output int lat);
    req = 1'b1; we = w; is_vector = v; address = a; wd = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    r = rd;
    e = err;
  endtask

  initial begin
    logic [S*L-1:0] r;
    logic e;
    int lat;
    int n;
    int addrs [3];

    tv[0]  = '{1'b1, 1'b1, 4'd0,  {32'h103, 32'h102, 32'h101, 32'h100}, '0, 1'b0, 5};
    tv[1]  = '{1'b1, 1'b1, 4'd4,  {32'h107, 32'h106, 32'h105, 32'h104}, '0, 1'b0, 5};
    tv[2]  = '{1'b1, 1'b1, 4'd8,  {32'h10B, 32'h10A, 32'h109, 32'h108}, '0, 1'b0, 5};
    tv[3]  = '{1'b1, 1'b1, 4'd12, {32'h10F, 32'h10E, 32'h10D, 32'h10C}, '0, 1'b0, 5};
    tv[4]  = '{1'b1, 1'b0, 4'd5,  {96'h0, 32'hDEADBEEF}, '0, 1'b0, 2};
    tv[5]  = '{1'b0, 1'b0, 4'd5,  '0, {96'h0, 32'hDEADBEEF}, 1'b0, 2};
    tv[6]  = '{1'b1, 1'b1, 4'd8,  {32'h4, 32'h3, 32'h2, 32'h1}, '0, 1'b0, 5};
    tv[7]  = '{1'b0, 1'b1, 4'd8,  '0, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 5};
    tv[8]  = '{1'b1, 1'b1, 4'd14, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, '0, 1'b1, 5};
    tv[9]  = '{1'b0, 1'b1, 4'd14, '0, {32'h0, 32'h0, 32'hA1, 32'hA0}, 1'b1, 5};
    tv[10] = '{1'b0, 1'b0, 4'd15, '0, {96'h0, 32'hA1}, 1'b0, 2};
    tv[11] = '{1'b0, 1'b1, 4'd12, '0, {32'hA1, 32'hA0, 32'h10D, 32'h10C}, 1'b0, 5};
    tv[12] = '{1'b0, 1'b1, 4'd0,  '0, {32'h103, 32'h102, 32'h101, 32'h100}, 1'b0, 5};
    tv[13] = '{1'b0, 1'b0, 4'd4,  '0, {96'h0, 32'h104}, 1'b0, 2};
    for (int i = 0; i < D; i++) tb_mem[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", rd, '0);
    chk("rst_done_err", {done, err}, '0);
    chk("rst_dump", {dump_valid, dump_addr, dump_data, dump_done}, '0);
    rst = 1'b0;
    #1;
    chk("rst_ready", ready, 1);

    for (int i = 0; i < 14; i++) begin
      access(tv[i].w, tv[i].v, tv[i].a, tv[i].d, r, e, lat);
      chk($sformatf("vec%0d_lat", i), lat, tv[i].exp_lat);
      chk($sformatf("vec%0d_err", i), e, tv[i].exp_err);
      if (!tv[i].w) chk($sformatf("vec%0d_rd", i), r, tv[i].exp_rd);
      if (tv[i].w) begin
        n = tv[i].v ? L : 1;
        for (int k = 0; k < n; k++)
          if (int'(tv[i].a) + k < D) tb_mem[int'(tv[i].a) + k] = tv[i].d[k*S +: S];
      end
      @(posedge clk); #1;
    end

    // Dump wins over a simultaneous req; req stays high and is taken afterwards
    dump_start = 1'b1; req = 1'b1; we = 1'b0; is_vector = 1'b0; address = 4'd3;
    @(posedge clk); #1;
    dump_start = 1'b0;
    chk("dump_ready_low", ready, 0);
    lat = 0;
    while (!dump_valid && lat < 5) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < D; i++) begin
      chk($sformatf("dump%0d_valid_done", i), {dump_valid, done, dump_done},
          {1'b1, 1'b0, (i == D - 1)});
      chk($sformatf("dump%0d_addr", i), dump_addr, i);
      chk($sformatf("dump%0d_data", i), dump_data, tb_mem[i]);
      if (i < D - 1) begin
        @(posedge clk); #1;
      end
    end
    chk("dump_end_ready", ready, 1);
    @(posedge clk); #1;
    req = 1'b0;
    chk("dump_valid_off", dump_valid, 0);
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("post_dump_lat", lat, 2);
    chk("post_dump_rd", rd, {96'h0, tb_mem[3]});
    @(posedge clk); #1;

    // Reset while lane 2 of a vector write is pending
    req = 1'b1; we = 1'b1; is_vector = 1'b1; address = 4'd0;
    wd = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_rd", rd, '0);
    chk("abort_done_ready", {done, err, ready}, 3'b001);
    @(posedge clk); #1;
    rst = 1'b0;
    tb_mem[0] = 32'hC0;
    tb_mem[1] = 32'hC1;
    access(1'b0, 1'b1, 4'd0, '0, r, e, lat);
    chk("abort_readback", r, {tb_mem[3], tb_mem[2], 32'hC1, 32'hC0});
    @(posedge clk); #1;

    // req held high: three scalar reads accepted on consecutive done cycles
    addrs[0] = 1; addrs[1] = 6; addrs[2] = 9;
    req = 1'b1; we = 1'b0; is_vector = 1'b0; address = 4'(addrs[0]);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) address = 4'(addrs[i+1]);
      else req = 1'b0;
      lat = 0;
      while (!done && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("b2b%0d_gap", i), lat, 1);
      chk($sformatf("b2b%0d_ready", i), ready, 1);
      chk($sformatf("b2b%0d_rd", i), rd, {96'h0, tb_mem[addrs[i]]});
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
